// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and widths.
package lsu_pkg;

  localparam int DATA_W = 32;
  localparam int MEM_AW = 12;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_ILL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RWAIT,
    ST_WR,
    ST_RESP
  } state_t;

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake between the execute stage (master) and the LSU (slave).
interface lsu_if;
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_size;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts/extends a load result and merges sub-word store data
// into the previously read word (little-endian lanes).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] new_data,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged_word
);

  logic [4:0]  byte_pos;
  logic [4:0]  half_pos;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign byte_pos = {lane, 3'b000};
  assign half_pos = {lane[1], 4'b0000};
  assign sel_byte = old_word[byte_pos +: 8];
  assign sel_half = old_word[half_pos +: 16];

  always_comb begin
    load_data   = old_word;
    merged_word = new_data;
    case (size)
      SZ_B: begin
        load_data   = {{(DATA_W-8){sel_byte[7] & ~is_unsigned}}, sel_byte};
        merged_word = old_word;
        merged_word[byte_pos +: 8] = new_data[7:0];
      end
      SZ_H: begin
        load_data   = {{(DATA_W-16){sel_half[15] & ~is_unsigned}}, sel_half};
        merged_word = old_word;
        merged_word[half_pos +: 16] = new_data[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one load/store per handshake, read-modify-write for sub-word stores,
// errors reported without touching memory. Every output comes straight from a register.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = lsu_pkg::MEM_AW,
  parameter int DATA_W = lsu_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  lsu_if.slave              bus,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t              state, state_n;
  logic                op_we, op_we_n;
  logic [2:0]          op_size, op_size_n;
  logic [1:0]          op_lane, op_lane_n;
  logic [DATA_W-1:0]   op_wdata, op_wdata_n;
  logic                rsp_err_q, rsp_err_n;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_n;
  logic [MEM_AW-1:0]   mem_addr_n;
  logic [DATA_W-1:0]   mem_wdata_n;
  logic                mem_re_n, mem_we_n;
  logic                req_ready_q, rsp_valid_q;
  logic                req_err;
  logic [DATA_W-1:0]   load_data, merged_word;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign req_err = (bus.req_size[1:0] == SZ_ILL)
                || (bus.req_size[1:0] == SZ_H && bus.req_addr[0])
                || (bus.req_size[1:0] == SZ_W && bus.req_addr[1:0] != 2'b00)
                || ((bus.req_addr >> (MEM_AW + 2)) != 32'd0);

  lsu_lane_align u_align (
    .size        (op_size[1:0]),
    .is_unsigned (op_size[2]),
    .lane        (op_lane),
    .old_word    (mem_rdata),
    .new_data    (op_wdata),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Next-state logic also computes the next value of every registered output.
  always_comb begin
    state_n     = state;
    op_we_n     = op_we;
    op_size_n   = op_size;
    op_lane_n   = op_lane;
    op_wdata_n  = op_wdata;
    rsp_err_n   = rsp_err_q;
    rsp_rdata_n = rsp_rdata_q;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    mem_re_n    = 1'b0;
    mem_we_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          op_we_n    = bus.req_we;
          op_size_n  = bus.req_size;
          op_lane_n  = bus.req_addr[1:0];
          op_wdata_n = bus.req_wdata;
          mem_addr_n = bus.req_addr[MEM_AW+1:2];
          if (req_err) begin
            state_n     = ST_RESP;
            rsp_err_n   = 1'b1;
            rsp_rdata_n = '0;
          end else if (bus.req_we && bus.req_size[1:0] == SZ_W) begin
            state_n     = ST_WR;
            mem_we_n    = 1'b1;
            mem_wdata_n = bus.req_wdata;
          end else begin
            state_n  = ST_RD;
            mem_re_n = 1'b1;
          end
        end
      end
      ST_RD: state_n = ST_RWAIT;
      ST_RWAIT: begin
        if (op_we) begin
          state_n     = ST_WR;
          mem_we_n    = 1'b1;
          mem_wdata_n = merged_word;
        end else begin
          state_n     = ST_RESP;
          rsp_err_n   = 1'b0;
          rsp_rdata_n = load_data;
        end
      end
      ST_WR: begin
        state_n     = ST_RESP;
        rsp_err_n   = 1'b0;
        rsp_rdata_n = '0;
      end
      ST_RESP: if (bus.rsp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      op_we       <= 1'b0;
      op_size     <= '0;
      op_lane     <= '0;
      op_wdata    <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_addr    <= '0;
      mem_re      <= 1'b0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
    end else begin
      state       <= state_n;
      op_we       <= op_we_n;
      op_size     <= op_size_n;
      op_lane     <= op_lane_n;
      op_wdata    <= op_wdata_n;
      req_ready_q <= (state_n == ST_IDLE);
      rsp_valid_q <= (state_n == ST_RESP);
      rsp_err_q   <= rsp_err_n;
      rsp_rdata_q <= rsp_rdata_n;
      mem_addr    <= mem_addr_n;
      mem_re      <= mem_re_n;
      mem_we      <= mem_we_n;
      mem_wdata   <= mem_wdata_n;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-array reference model predicts every response
// and memory write; a negedge monitor compares them as the DUT presents them.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          stall;
    int          accept_cycle;
  } exp_t;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        reset_n;
  logic [11:0] mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu_if bus();

  load_store_unit #(.MEM_AW(12), .DATA_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  exp_t        exp_q[$];
  wr_t         wr_q[$];

  int          errors = 0;
  int          checks = 0;
  int          cycle  = 0;
  int          next_stall = 0;
  bit          in_reset_test = 0;
  bit          in_resp, hs_pending, prev_we, prev_re;
  int          stall_left;
  logic [31:0] held_rdata;
  logic        held_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Registered-read data memory seen by the DUT.
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic we, input logic [2:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] w, v, mask;
    int          sh, wa, waited;
    bit          err;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = size;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    waited = 0;
    while (!bus.req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.req_ready) begin
      check_output("req_ready_timeout", {31'b0, bus.req_ready}, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    wa   = int'(addr[13:2]);
    sh   = 8 * int'(addr[1:0]);
    err  = (size[1:0] == 2'b11) || (size[1:0] == 2'b01 && addr[0])
        || (size[1:0] == 2'b10 && addr[1:0] != 2'b00) || (addr >= 32'h4000);
    case (size[1:0])
      2'b00:   mask = 32'h0000_00FF;
      2'b01:   mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    e.rdata = 32'd0;
    e.err   = err;
    e.stall = next_stall;
    e.accept_cycle = cycle;
    next_stall = 0;
    if (err) begin
      e.lat = 1;
    end else if (we) begin
      w = ref_mem[wa];
      ref_mem[wa] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
      wr_q.push_back('{addr: addr[13:2], data: ref_mem[wa]});
      e.lat = (size[1:0] == 2'b10) ? 2 : 4;
    end else begin
      v = (ref_mem[wa] >> sh) & mask;
      if (!size[2] && size[1:0] == 2'b00 && v >= 32'd128)   v = v - 32'd256;
      if (!size[2] && size[1:0] == 2'b01 && v >= 32'd32768) v = v - 32'd65536;
      e.rdata = v;
      e.lat   = 3;
    end
    exp_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || in_resp || hs_pending) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("drain", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_req_ready"}, {31'b0, bus.req_ready}, 32'd1);
    check_output({tag, "_rsp_flags"}, {30'b0, bus.rsp_valid, bus.rsp_err}, 32'd0);
    check_output({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
    check_output({tag, "_mem_strobes"}, {30'b0, mem_re, mem_we}, 32'd0);
    check_output({tag, "_mem_addr"}, {20'b0, mem_addr}, 32'd0);
    check_output({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  // Monitor: memory-write scoreboard, response scoreboard, latency and back-pressure stability.
  initial begin
    exp_t e;
    wr_t  wr;
    bus.rsp_ready = 1'b0;
    in_resp = 0; hs_pending = 0; prev_we = 0; prev_re = 0; stall_left = 0;
    forever begin
      @(negedge clk);
      if (!reset_n || in_reset_test) begin
        bus.rsp_ready = 1'b0;
        in_resp = 0; hs_pending = 0; prev_we = 0; prev_re = 0; stall_left = 0;
      end else begin
        if (mem_we) begin
          check_output("re_during_we", {31'b0, mem_re}, 32'd0);
          if (prev_we) check_output("we_single_cycle", {31'b0, prev_we}, 32'd0);
          if (wr_q.size() == 0) begin
            check_output("unexpected_write", {31'b0, mem_we}, 32'd0);
          end else begin
            wr = wr_q.pop_front();
            check_output("mem_addr", {20'b0, mem_addr}, {20'b0, wr.addr});
            check_output("mem_wdata", mem_wdata, wr.data);
          end
        end
        if (mem_re && prev_re) check_output("re_single_cycle", {31'b0, prev_re}, 32'd0);
        prev_we = mem_we;
        prev_re = mem_re;

        if (hs_pending) begin
          check_output("idle_after_rsp", {30'b0, bus.req_ready, bus.rsp_valid}, 32'd2);
          hs_pending = 0;
        end
        if (bus.rsp_valid) begin
          if (!in_resp) begin
            in_resp = 1;
            if (exp_q.size() == 0) begin
              check_output("unexpected_rsp", {31'b0, bus.rsp_valid}, 32'd0);
              stall_left = 0;
            end else begin
              e = exp_q.pop_front();
              check_output("latency", 32'(cycle - e.accept_cycle), 32'(e.lat));
              check_output("rsp_err", {31'b0, bus.rsp_err}, {31'b0, e.err});
              check_output("rsp_rdata", bus.rsp_rdata, e.rdata);
              stall_left = e.stall;
            end
            held_rdata = bus.rsp_rdata;
            held_err   = bus.rsp_err;
          end else begin
            check_output("hold_rdata", bus.rsp_rdata, held_rdata);
            check_output("hold_err", {31'b0, bus.rsp_err}, {31'b0, held_err});
          end
          check_output("req_ready_in_resp", {31'b0, bus.req_ready}, 32'd0);
          if (stall_left > 0) begin
            stall_left--;
            bus.rsp_ready = 1'b0;
          end else begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
          end
          if (bus.rsp_ready) begin
            hs_pending = 1;
            in_resp    = 0;
          end
        end else begin
          bus.rsp_ready = ($urandom_range(0, 1) != 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus: reset, directed scenarios, randomized traffic, reset during RWAIT.
  initial begin
    logic [31:0] saved;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    mem_rdata     = 32'd0;
    reset_n       = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 3'd0;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;

    apply_stimulus(1'b1, 3'b010, 32'h40, 32'hDEADBEEF);
    apply_stimulus(1'b0, 3'b000, 32'h41, 32'd0);
    apply_stimulus(1'b0, 3'b100, 32'h41, 32'd0);
    apply_stimulus(1'b0, 3'b001, 32'h42, 32'd0);
    apply_stimulus(1'b1, 3'b000, 32'h43, 32'h12);
    apply_stimulus(1'b0, 3'b010, 32'h40, 32'd0);
    apply_stimulus(1'b0, 3'b010, 32'h42, 32'd0);
    apply_stimulus(1'b1, 3'b001, 32'h41, 32'h5555);
    apply_stimulus(1'b0, 3'b011, 32'h40, 32'd0);
    apply_stimulus(1'b0, 3'b010, 32'h4000, 32'd0);
    next_stall = 5;
    apply_stimulus(1'b0, 3'b010, 32'h40, 32'd0);
    drain();

    for (int i = 0; i < 250; i++) begin
      logic        we_r;
      logic [2:0]  sz;
      logic [31:0] a;
      we_r = 1'($urandom_range(0, 1));
      sz   = 3'($urandom_range(0, 7));
      a    = 32'h40 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0) begin
        if (sz[1:0] == 2'b01) a[0] = 1'b0;
        if (sz[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 15) == 0) a[$urandom_range(14, 31)] = 1'b1;
      if ($urandom_range(0, 9) == 0) next_stall = $urandom_range(1, 6);
      apply_stimulus(we_r, sz, a, $urandom);
    end
    drain();

    saved = ref_mem[17];
    apply_stimulus(1'b1, 3'b000, 32'h45, 32'hA5);
    @(negedge clk);
    reset_n = 1'b0;
    in_reset_test = 1;
    exp_q.delete();
    wr_q.delete();
    ref_mem[17] = saved;
    @(negedge clk);
    check_reset_values("rwait_reset");
    reset_n = 1'b1;
    @(negedge clk);
    in_reset_test = 0;

    apply_stimulus(1'b0, 3'b010, 32'h44, 32'd0);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 2)),
                     32'h44 & ~32'h3, $urandom);
    end
    drain();
    check_output("pending_writes", wr_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
